// File: rtl/axi_llc_way_arbiter_if.sv
// axi_llc_way_arbiter_if: request/response bundle between the requesting units, the data ways and the way arbiter.
// Ports (arbiter side = slave): req_* per-unit requests in, req_ready_o out; way_inp_* request to the data ways;
// way_out_* response from the data ways; rsp_* one-hot routed response to the units; outstanding_o, err_o status.
interface axi_llc_way_arbiter_if #(
  parameter int NumUnits = 4,
  parameter int MaxOutstanding = 4,
  parameter type way_inp_t = logic,
  parameter type way_oup_t = logic
);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  way_inp_t req_i [NumUnits];
  logic [NumUnits-1:0] req_valid_i, req_last_i, req_rsp_i, req_ready_o;
  way_inp_t way_inp_o;
  logic way_inp_valid_o, way_inp_ready_i;
  way_oup_t way_out_i;
  logic way_out_valid_i, way_out_ready_o;
  way_oup_t rsp_o;
  logic [NumUnits-1:0] rsp_valid_o, rsp_ready_i;
  logic [CntW-1:0] outstanding_o;
  logic err_o;
  modport slave (
    input req_i, req_valid_i, req_last_i, req_rsp_i, way_inp_ready_i, way_out_i, way_out_valid_i, rsp_ready_i,
    output req_ready_o, way_inp_o, way_inp_valid_o, way_out_ready_o, rsp_o, rsp_valid_o, outstanding_o, err_o
  );
  modport master (
    output req_i, req_valid_i, req_last_i, req_rsp_i, way_inp_ready_i, way_out_i, way_out_valid_i, rsp_ready_i,
    input req_ready_o, way_inp_o, way_inp_valid_o, way_out_ready_o, rsp_o, rsp_valid_o, outstanding_o, err_o
  );
endinterface

// File: rtl/axi_llc_way_arbiter.sv
// axi_llc_way_arbiter: round-robin burst-locking arbiter onto the data ways with in-order response routing.
// Ports: clk_i clock, rst_ni sync active-low reset, bus (slave modport) carrying all request/response signals.
module axi_llc_way_arbiter #(
  parameter int NumUnits = 4,
  parameter int MaxOutstanding = 4,
  parameter type way_inp_t = logic,
  parameter type way_oup_t = logic
) (
  input logic clk_i,
  input logic rst_ni,
  axi_llc_way_arbiter_if.slave bus
);
  localparam int IdxW = NumUnits > 1 ? $clog2(NumUnits) : 1;
  localparam int PtrW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [IdxW-1:0] hold_idx, prio, arb, cand, winner, head, nxt_idx;
  logic [IdxW-1:0] q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count;
  logic err, full, empty, blocked, valid, hs, last, push, pop;
  way_inp_t inp;
  way_oup_t oup;
  // scan downwards so the first valid unit at or after prio is the last assignment
  always_comb begin
    arb = prio;
    cand = '0;
    for (int i = NumUnits - 1; i >= 0; i--) begin
      cand = IdxW'((int'(prio) + i) % NumUnits);
      if (bus.req_valid_i[cand]) arb = cand;
    end
  end
  assign winner = state == HOLD ? hold_idx : arb;
  assign full = count == CntW'(MaxOutstanding);
  assign empty = count == '0;
  // full is registered, so a pop in the same cycle cannot unblock a read
  assign blocked = bus.req_rsp_i[winner] && full;
  assign valid = bus.req_valid_i[winner] && !blocked;
  assign hs = valid && bus.way_inp_ready_i;
  assign last = bus.req_last_i[winner];
  assign push = hs && bus.req_rsp_i[winner];
  assign head = q[rd_ptr];
  assign pop = !empty && bus.way_out_valid_i && bus.rsp_ready_i[head];
  assign nxt_idx = winner == IdxW'(NumUnits - 1) ? '0 : winner + 1'b1;
  assign inp = bus.req_i[winner];
  assign oup = bus.way_out_i;
  assign bus.way_inp_o = inp;
  assign bus.way_inp_valid_o = valid;
  assign bus.req_ready_o = {NumUnits{bus.way_inp_ready_i && !blocked}} & (NumUnits'(1) << winner);
  assign bus.rsp_o = oup;
  assign bus.rsp_valid_o = empty ? '0 : {NumUnits{bus.way_out_valid_i}} & (NumUnits'(1) << head);
  // with nothing queued the response channel drains
  assign bus.way_out_ready_o = empty || bus.rsp_ready_i[head];
  assign bus.outstanding_o = count;
  assign bus.err_o = err;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      hold_idx <= '0;
      prio <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && valid && !(hs && last)) begin
        state <= HOLD;
        hold_idx <= arb;
      end else if (state == HOLD && hs && last) begin
        state <= IDLE;
      end
      if (hs && last) prio <= nxt_idx;
      if (push) begin
        q[wr_ptr] <= winner;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CntW'(push) - CntW'(pop);
      if (empty && bus.way_out_valid_i) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_llc_way_arbiter.sv
// tb_axi_llc_way_arbiter: scoreboard bench for the way arbiter.
module tb_axi_llc_way_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int sb[$];
  always #5 clk = ~clk;
  axi_llc_way_arbiter_if #(
    .NumUnits(4), .MaxOutstanding(4), .way_inp_t(logic [7:0]), .way_oup_t(logic [7:0])
  ) bus ();
  axi_llc_way_arbiter #(
    .NumUnits(4), .MaxOutstanding(4), .way_inp_t(logic [7:0]), .way_oup_t(logic [7:0])
  ) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_sb(input string tag, input int got);
    if (sb.size() == 0) check({tag, "_sb_empty"}, got, -1);
    else check(tag, got, sb.pop_front());
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    for (int i = 0; i < 4; i++) bus.req_i[i] = 8'(16 + i);
    bus.req_valid_i = '0;
    bus.req_last_i = '0;
    bus.req_rsp_i = '0;
    bus.way_inp_ready_i = 1'b0;
    bus.way_out_i = '0;
    bus.way_out_valid_i = 1'b0;
    bus.rsp_ready_i = '0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    clear();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask
  function automatic int grant();
    return int'(bus.way_inp_o) - 16;
  endfunction
  initial begin
    int order[3];
    order = '{0, 3, 0};
    clear();
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    check("rst_inp_valid", int'(bus.way_inp_valid_o), 0);
    check("rst_req_ready", int'(bus.req_ready_o), 0);
    check("rst_rsp_valid", int'(bus.rsp_valid_o), 0);
    check("rst_out_ready", int'(bus.way_out_ready_o), 1);
    check("rst_outstanding", int'(bus.outstanding_o), 0);
    check("rst_err", int'(bus.err_o), 0);
    cyc();
    rst_n = 1'b1;
    // round robin between units 0 and 3
    bus.req_valid_i = 4'b1001;
    bus.req_last_i = 4'b1111;
    bus.way_inp_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb.push_back(k % 2 == 1 ? 3 : 0);
      @(negedge clk);
      check_sb("rr_grant", grant());
      check("rr_ready", int'(bus.req_ready_o), k % 2 == 1 ? 8 : 1);
      cyc();
    end
    // four-beat burst from unit 0 holds the grant while ready toggles
    do_reset();
    for (int k = 0; k < 7; k++) begin
      bus.req_valid_i = 4'b0011;
      bus.way_inp_ready_i = k % 2 == 0;
      bus.req_last_i = k == 6 ? 4'b0001 : 4'b0000;
      sb.push_back(0);
      @(negedge clk);
      check_sb("burst_grant", grant());
      check("burst_ready", int'(bus.req_ready_o), k % 2 == 0 ? 1 : 0);
      cyc();
    end
    bus.req_last_i = 4'b0011;
    bus.way_inp_ready_i = 1'b1;
    sb.push_back(1);
    @(negedge clk);
    check_sb("burst_ptr1", grant());
    cyc();
    sb.push_back(0);
    @(negedge clk);
    check_sb("burst_ptr2", grant());
    cyc();
    // queue fills with reads from unit 3, fifth blocked until a pop
    do_reset();
    bus.req_valid_i = 4'b1000;
    bus.req_last_i = 4'b1000;
    bus.req_rsp_i = 4'b1000;
    bus.way_inp_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb.push_back(k);
      @(negedge clk);
      check_sb("fill_count", int'(bus.outstanding_o));
      check("fill_valid", int'(bus.way_inp_valid_o), 1);
      cyc();
    end
    @(negedge clk);
    check("full_count", int'(bus.outstanding_o), 4);
    check("full_valid", int'(bus.way_inp_valid_o), 0);
    check("full_ready", int'(bus.req_ready_o), 0);
    cyc();
    bus.way_out_valid_i = 1'b1;
    bus.way_out_i = 8'h55;
    bus.rsp_ready_i = 4'b1000;
    @(negedge clk);
    check("pop_rsp_valid", int'(bus.rsp_valid_o), 8);
    check("pop_still_blocked", int'(bus.way_inp_valid_o), 0);
    cyc();
    bus.way_out_valid_i = 1'b0;
    @(negedge clk);
    check("after_pop_valid", int'(bus.way_inp_valid_o), 1);
    check("after_pop_ready", int'(bus.req_ready_o), 8);
    check("after_pop_count", int'(bus.outstanding_o), 3);
    cyc();
    bus.req_valid_i = '0;
    @(negedge clk);
    check("refill_count", int'(bus.outstanding_o), 4);
    // interleaved reads 0,3,0 returned in order
    do_reset();
    bus.way_inp_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req_valid_i = 4'(1 << order[k]);
      bus.req_last_i = 4'(1 << order[k]);
      bus.req_rsp_i = 4'(1 << order[k]);
      sb.push_back(1 << order[k]);
      @(negedge clk);
      check("read_grant", grant(), order[k]);
      cyc();
    end
    bus.req_valid_i = '0;
    bus.way_out_valid_i = 1'b1;
    bus.way_out_i = 8'hA0;
    bus.rsp_ready_i = '0;
    @(negedge clk);
    check("stall_out_ready", int'(bus.way_out_ready_o), 0);
    check("stall_count", int'(bus.outstanding_o), 3);
    cyc();
    for (int k = 0; k < 3; k++) begin
      bus.way_out_i = 8'(8'hA0 + k);
      bus.rsp_ready_i = 4'hF;
      @(negedge clk);
      check_sb("rsp_onehot", int'(bus.rsp_valid_o));
      check("rsp_data", int'(bus.rsp_o), 8'hA0 + k);
      check("rsp_out_ready", int'(bus.way_out_ready_o), 1);
      cyc();
    end
    bus.way_out_valid_i = 1'b0;
    @(negedge clk);
    check("rsp_drained", int'(bus.outstanding_o), 0);
    // response with an empty queue
    do_reset();
    bus.way_out_valid_i = 1'b1;
    @(negedge clk);
    check("drain_ready", int'(bus.way_out_ready_o), 1);
    check("drain_rsp_valid", int'(bus.rsp_valid_o), 0);
    check("err_before", int'(bus.err_o), 0);
    cyc();
    bus.way_out_valid_i = 1'b0;
    @(negedge clk);
    check("err_set", int'(bus.err_o), 1);
    cyc();
    @(negedge clk);
    check("err_sticky", int'(bus.err_o), 1);
    // reset in HOLD with two reads outstanding
    bus.req_valid_i = 4'b0010;
    bus.req_rsp_i = 4'b0010;
    bus.req_last_i = '0;
    bus.way_inp_ready_i = 1'b1;
    cyc();
    cyc();
    bus.way_inp_ready_i = 1'b0;
    @(negedge clk);
    check("hold_count", int'(bus.outstanding_o), 2);
    check("hold_grant", grant(), 1);
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.req_valid_i = 4'b0011;
    bus.req_last_i = 4'b0011;
    bus.req_rsp_i = '0;
    bus.way_inp_ready_i = 1'b1;
    @(negedge clk);
    check("mid_rst_grant", grant(), 0);
    check("mid_rst_count", int'(bus.outstanding_o), 0);
    check("mid_rst_err", int'(bus.err_o), 0);
    check("mid_rst_rsp_valid", int'(bus.rsp_valid_o), 0);
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_llc_way_arbiter.md
AXI_LLC_WAY_ARBITER -- requirements
Module: axi_llc_way_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- NumUnits, default 4, number of requesting units (0=Evict, 1=Refill, 2=Write, 3=Read).
- MaxOutstanding, default 4, depth of the response-routing queue (power of two, >=2).
- way_inp_t, default logic, data way request payload.
- way_oup_t, default logic, data way response payload.
REQ-002 The block SHALL have these ports, all synchronous to clk_i:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- req_i  in  NumUnits x way_inp_t  per-unit request payload.
- req_valid_i  in  NumUnits  per-unit request valid.
- req_last_i  in  NumUnits  request is last of a burst; releases the lock.
- req_rsp_i  in  NumUnits  request expects a data way response (read).
- req_ready_o  out  NumUnits  per-unit request accepted.
- way_inp_o  out  way_inp_t  request to data ways.
- way_inp_valid_o  out  1  request valid.
- way_inp_ready_i  in  1  data ways accept the request.
- way_out_i  in  way_oup_t  data way response.
- way_out_valid_i  in  1  response valid.
- way_out_ready_o  out  1  response accepted.
- rsp_o  out  way_oup_t  response payload, broadcast to all units.
- rsp_valid_o  out  NumUnits  response valid, one-hot.
- rsp_ready_i  in  NumUnits  unit accepts response.
- outstanding_o  out  $clog2(MaxOutstanding+1)  queued responses.
- err_o  out  1  sticky error: response arrived with the queue empty.

Function
REQ-003 Arbitration SHALL be round-robin: the winner is the first valid unit at or after the priority pointer, wrapping modulo NumUnits.
REQ-004 way_inp_o SHALL equal req_i[winner] and way_inp_valid_o SHALL equal req_valid_i[winner] gated by REQ-007; req_ready_o[winner] SHALL equal way_inp_ready_i, and all other req_ready_o SHALL be 0.
REQ-005 States:
- IDLE: no grant held; arbitrate combinationally each cycle.
- HOLD: the winner index is registered and no arbitration occurs.
REQ-006 Transitions:
- IDLE->HOLD when way_inp_valid_o=1 and either way_inp_ready_i=0, or the handshake has req_last_i=0.
- HOLD->IDLE on a handshake with req_last_i[winner]=1.
- A handshake with last=1 in IDLE stays in IDLE.
REQ-007 In HOLD, a drop of req_valid_i[winner] SHALL NOT release the grant; way_inp_valid_o SHALL follow req_valid_i[winner].
REQ-008 A request with req_rsp_i=1 SHALL be blocked (valid out 0, ready 0) while the queue is full. A simultaneous pop SHALL NOT unblock it in the same cycle.
REQ-009 On every handshake with last=1, the priority pointer SHALL advance to (winner+1) mod NumUnits. A handshake with last=0 SHALL NOT move the pointer.
REQ-010 A handshake with req_rsp_i=1 SHALL push the winner index into the response queue. A handshake with req_rsp_i=0 SHALL NOT push.
REQ-011 Response routing: with the queue non-empty, rsp_valid_o[head]=way_out_valid_i, way_out_ready_o=rsp_ready_i[head], and rsp_o=way_out_i. A handshake SHALL pop the head.
REQ-012 With the queue empty, way_out_ready_o SHALL be 1 (drain) and rsp_valid_o SHALL be 0. If way_out_valid_i=1 in that case, err_o SHALL be set on the next cycle and stay set until reset.
REQ-013 A simultaneous push and pop on a non-full, non-empty queue SHALL leave outstanding_o unchanged. Pointers SHALL wrap modulo MaxOutstanding.
REQ-014 The request path SHALL add zero latency (combinational). outstanding_o SHALL update one cycle after a handshake.

Reset
REQ-015 With rst_ni=0 at a rising edge, the block SHALL clear the state to IDLE, the priority pointer to 0, the queue to empty, and err_o to 0.
REQ-016 During and after reset, way_inp_valid_o, req_ready_o and rsp_valid_o SHALL be 0 until new inputs arrive. way_out_ready_o SHALL be 1.
REQ-017 A reset mid-burst or mid-response SHALL discard the held grant and all queued indices with no further output.

Verification
REQ-018 Units 0 and 3 valid, single-beat, ready=1, after reset -> grants 0,3,0,3 on consecutive cycles.
REQ-019 Unit 0 issues 4 beats (last only on beat 4), unit 1 valid throughout, ready toggles 1/0 -> unit 1 is not granted until after beat 4; then the pointer is 1.
REQ-020 MaxOutstanding=4, unit 3 issues 5 reads with no responses -> 4 accepted, outstanding_o=4, 5th blocked until a pop. It is accepted the cycle after the pop.
REQ-021 Interleaved reads 0,3,0 with responses returned in order -> rsp_valid_o one-hot 0001,1000,0001; rsp_ready_i=0 stalls way_out_ready_o.
REQ-022 way_out_valid_i=1 with an empty queue -> way_out_ready_o=1 and err_o=1 from the next cycle on.
REQ-023 Reset asserted in HOLD with 2 outstanding -> next cycle IDLE, outstanding_o=0, pointer 0, err_o=0.
